// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// opcode constants, FSM state and access-size encodings, lane helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    // Access size from the primary opcode; unknown opcodes are word accesses.
    function automatic mem_size_t op_size(input logic [5:0] op);
        mem_size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = BYTE;
            OP_LH, OP_LHU, OP_SH: sz = HALF;
            default:              sz = WORD;
        endcase
        return sz;
    endfunction

    // Only LB and LH sign-extend.
    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    // Little-endian byte enables for the addressed lane(s).
    function automatic logic [3:0] lane_be(input mem_size_t sz, input logic [1:0] lo);
        logic [3:0] be;
        case (sz)
            BYTE:    be = 4'b0001 << lo;
            HALF:    be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes so the byte enables pick it out.
    function automatic logic [31:0] lane_wdata(input mem_size_t sz, input logic [31:0] data);
        logic [31:0] wd;
        case (sz)
            BYTE:    wd = {4{data[7:0]}};
            HALF:    wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input mem_size_t sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            BYTE:    bad = 1'b0;
            HALF:    bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword lane from a read word and
// sign- or zero-extends it to 32 bits.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  mem_size_t   size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        data   = rdata;
        case (addr)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        if (addr[1]) begin
            w_half = rdata[31:16];
        end else begin
            w_half = rdata[15:0];
        end
        case (size)
            BYTE:    data = {{24{sign & w_byte[7]}}, w_byte};
            HALF:    data = {{16{sign & w_half[15]}}, w_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns EX/MEM loads/stores into a
// req/ack bus transaction, aligns lanes, flags misalignment and stalls
// the upstream pipeline until the access completes.
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_result,
    input  logic [31:0] mem_busB,
    input  logic        mem_memwr,
    input  logic [1:0]  mem_memtoreg,
    input  logic [5:0]  mem_op,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        addr_err
);

    mem_state_t  r_state;
    mem_state_t  w_next_state;

    logic        w_access;
    logic        w_is_store;
    mem_size_t   w_size;
    logic        w_misaligned;
    logic        w_issue;
    logic        w_fault;
    logic        w_capture;
    logic [31:0] w_aligned;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    mem_size_t   r_size;
    logic        r_sign;
    logic [1:0]  r_lo;
    logic        r_is_load;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_addr_err;

    // A store wins when both store and load are flagged.
    assign w_is_store   = mem_memwr;
    assign w_access     = mem_memwr | (mem_memtoreg == 2'b01);
    assign w_size       = op_size(mem_op);
    assign w_misaligned = is_misaligned(w_size, mem_result[1:0]);

    mem_load_align u_align (
        .rdata (dm_rdata),
        .addr  (r_lo),
        .size  (r_size),
        .sign  (r_sign),
        .data  (w_aligned)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; stall is combinational so it rises with the access.
    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        w_issue      = 1'b0;
        w_fault      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    stall = 1'b1;
                    if (w_misaligned) begin
                        w_fault      = 1'b1;
                        w_next_state = DONE;
                    end else begin
                        w_issue      = 1'b1;
                        w_next_state = REQ;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dm_ack) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_next_state = REQ;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request registers, load result capture and completion pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'h0000_0000;
            r_be         <= 4'h0;
            r_wdata      <= 32'h0000_0000;
            r_size       <= BYTE;
            r_sign       <= 1'b0;
            r_lo         <= 2'b00;
            r_is_load    <= 1'b0;
            r_load_data  <= 32'h0000_0000;
            r_load_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_req     <= 1'b1;
                r_we      <= w_is_store;
                r_addr    <= {mem_result[31:2], 2'b00};
                r_be      <= lane_be(w_size, mem_result[1:0]);
                r_wdata   <= lane_wdata(w_size, mem_busB);
                r_size    <= w_size;
                r_sign    <= op_signed(mem_op);
                r_lo      <= mem_result[1:0];
                r_is_load <= ~w_is_store;
            end else if (w_capture) begin
                r_req <= 1'b0;
            end
            if (w_capture && r_is_load) begin
                r_load_data <= w_aligned;
            end
            r_load_valid <= w_capture & r_is_load;
            r_addr_err   <= w_fault;
        end
    end

    assign dm_req     = r_req;
    assign dm_we      = r_we;
    assign dm_addr    = r_addr;
    assign dm_be      = r_be;
    assign dm_wdata   = r_wdata;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign addr_err   = r_addr_err;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the pipelined MIPS core. It consumes the EX/MEM pipeline register outputs (address, store data, write enable, load select, opcode) and drives a request/acknowledge data-memory bus. It handles byte and halfword lane alignment and flags misaligned addresses. It holds `stall` high so the EX/MEM register and all upstream stages freeze until the access completes.

## Interface
Parameters:
- none; all widths are fixed by the MIPS32 datapath.

Ports:
- `clk` in 1: the single clock; all state changes on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_result` in 32: effective address from the EX/MEM register.
- `mem_busB` in 32: store data.
- `mem_memwr` in 1: store instruction.
- `mem_memtoreg` in 2: `2'b01` means load.
- `mem_op` in 6: primary opcode; selects access size and sign.
- `dm_req` out 1: bus request.
- `dm_we` out 1: write.
- `dm_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: lane-replicated store data.
- `dm_ack` in 1: access complete. For reads, `dm_rdata` is valid in the same cycle.
- `dm_rdata` in 32: read word.
- `stall` out 1: freeze EX/MEM and earlier stages.
- `load_data` out 32: aligned, extended load result.
- `load_valid` out 1: `load_data` is valid this cycle.
- `addr_err` out 1: misaligned access, one-cycle pulse.

## Operation
- An access exists when `mem_memwr` is 1, or when `mem_memtoreg` is `2'b01`. If both are set, the access is treated as a store.
- Supported opcodes:
  - LB `0x20`, LH `0x21`, LW `0x23`, LBU `0x24`, LHU `0x25`
  - SB `0x28`, SH `0x29`, SW `0x2B`
  - Any other opcode on an access is treated as a word access.
- Misaligned access: a halfword access with `addr[0]=1`, or a word access with `addr[1:0]!=0`. No bus request is issued.
- Byte lanes are little-endian: lane n holds `addr[1:0]==n`, data bits `[8n+7:8n]`.
- Store data and byte enables:
  - SB: `dm_wdata={4{busB[7:0]}}`, `dm_be=4'b0001<<addr[1:0]`.
  - SH: `dm_wdata={2{busB[15:0]}}`, `dm_be` = `4'b1100` if `addr[1]`, else `4'b0011`.
  - SW: `dm_be=4'hF`.
- Load data: the selected lane(s) are extracted from `dm_rdata`. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- FSM states:
  - IDLE:
    - No access: `stall=0`.
    - Aligned access: `stall=1`. Latch address, be, wdata, we, size and sign into request registers; next state REQ.
    - Misaligned access: `stall=1`; next state DONE with the error flag set.
  - REQ: `dm_req=1`, `stall=1`. Request fields are held constant. On `dm_ack`, capture the aligned read data (loads only); next state DONE. With no ack, stay in REQ indefinitely.
  - DONE: `stall=0`. `load_valid=1` for a completed load, or `addr_err=1` for a misaligned access. The pipeline advances at the end of this cycle; next state IDLE.
- The EX/MEM inputs are guaranteed stable while `stall=1`. The unit samples them only in IDLE.

## Timing
- Reset values:
  - `dm_req=0`, `dm_we=0`, `dm_addr=0`, `dm_be=0`, `dm_wdata=0`
  - `stall=0`, `load_data=0`, `load_valid=0`, `addr_err=0`
  - state = IDLE
- `stall` is combinational from the IDLE decode, so it rises in the same cycle the access appears. All `dm_*` outputs and `load_data` are registered.
- Minimum latency is 3 cycles: the IDLE issue cycle, REQ with ack (zero-wait memory), then DONE. Each extra wait cycle of memory adds one cycle.
- A misaligned access takes 2 cycles: IDLE, then DONE.
- Back-to-back accesses: the next instruction is sampled in the IDLE cycle after DONE, with no extra bubble beyond this.
- A `dm_ack` seen in IDLE or DONE is ignored.
- Reset mid-REQ: `dm_req` drops immediately (asynchronously), and no DONE pulse is produced.

## Structure
- Shared package `mips_mem_pkg`: opcode constants (`OP_LB` … `OP_SW`), the `mem_state_t` enum (IDLE, REQ, DONE), and the size encoding (BYTE, HALF, WORD).
- One combinational sub-module, `mem_load_align`: inputs `rdata`, `addr[1:0]`, size, sign; output the extended 32-bit value. It is instantiated once.

## Test plan
- **SW, no wait:**
  - Stimulus: addr `0x100`, busB `0xDEADBEEF`, ack on the first REQ cycle.
  - Required: `dm_addr=0x100`, `be=F`, `wdata=DEADBEEF`, `we=1`; `stall` high for 2 cycles, low in DONE.
- **LB with 3 wait cycles:**
  - Stimulus: addr `0x203`, rdata `0x80112233`.
  - Required: `be=4'b1000` not driven for reads (`we=0`); `load_data=0xFFFFFF80`, `load_valid` for 1 cycle; `stall` high for 5 cycles.
- **LHU and SH:**
  - LHU at addr `0x002`, rdata `0xABCD1234` → `load_data=0x0000ABCD`.
  - SH at addr `0x002`, busB `0x5678` → `be=1100`, `wdata=0x56785678`.
- **Misaligned LW:**
  - Stimulus: LW at addr `0x101`.
  - Required: `dm_req` never asserted; `addr_err` pulses in cycle 2; `stall` high for 1 cycle.
- **Reset during REQ:**
  - Stimulus: assert `rst` while in REQ with no ack.
  - Required: `dm_req`, `stall` and `load_valid` all 0 immediately; the next access after reset runs normally.
- **Back-to-back SB then LW:**
  - Stimulus: SB followed immediately by LW.
  - Required: two distinct requests; the LW request begins in the cycle after SB's DONE; correct `be` values `0001` then `F`.
